// File: rtl/banked_regfile.sv
`timescale 1ns/1ps
// banked_regfile
// Multi-bank integer register file with trap-driven bank switching and a
// background bank clear engine.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_addr_i / rd_data_o       NRP packed read ports on the current bank,
//                               combinational, with same-cycle write bypass
//   wr_en_i/wr_addr_i/wr_data_i pipeline write into the current bank
//   x_bank_i/x_addr_i           cross-bank access select
//   x_we_i/x_wdata_i            cross-bank write
//   x_rdata_o                   cross-bank read data (no bypass)
//   trap_enter_i/trap_pc_i/trap_cause_i   trap entry and values to save
//   trap_ret_i                  return from trap
//   ret_pc_o                    saved trap PC (trap bank register 1)
//   cur_bank_o                  active bank (registered)
//   trap_err_o                  one-cycle pulse on a rejected trap event
//   clr_req_i/clr_bank_i        request zeroing of a whole bank
//   busy_o                      clear engine active (registered)
module banked_regfile #(
   parameter int XLEN      = 32,
   parameter int NBANKS    = 2,
   parameter int NREGS     = 32,
   parameter int NRP       = 2,
   parameter int TRAP_BANK = NBANKS - 1,
   localparam int AW       = $clog2(NREGS),
   localparam int BW       = $clog2(NBANKS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRP*AW-1:0]   rd_addr_i,
   output logic [NRP*XLEN-1:0] rd_data_o,
   input  logic                wr_en_i,
   input  logic [AW-1:0]       wr_addr_i,
   input  logic [XLEN-1:0]     wr_data_i,
   input  logic [BW-1:0]       x_bank_i,
   input  logic [AW-1:0]       x_addr_i,
   input  logic                x_we_i,
   input  logic [XLEN-1:0]     x_wdata_i,
   output logic [XLEN-1:0]     x_rdata_o,
   input  logic                trap_enter_i,
   input  logic [XLEN-1:0]     trap_pc_i,
   input  logic [XLEN-1:0]     trap_cause_i,
   input  logic                trap_ret_i,
   output logic [XLEN-1:0]     ret_pc_o,
   output logic [BW-1:0]       cur_bank_o,
   output logic                trap_err_o,
   input  logic                clr_req_i,
   input  logic [BW-1:0]       clr_bank_i,
   output logic                busy_o
);

   typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} clr_state_e;

   localparam logic [BW-1:0] TRAP_B   = BW'(TRAP_BANK);
   localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);
   // One bit per encodable bank index; only indices below NBANKS are real banks.
   localparam int            NSEL     = 1 << BW;
   localparam logic [NSEL-1:0] BANK_OK = NSEL'((64'd1 << NBANKS) - 64'd1);

   logic [XLEN-1:0] mem_q [NBANKS][NREGS];
   logic [XLEN-1:0] mem_d [NBANKS][NREGS];
   logic [BW-1:0]   cur_bank_q, cur_bank_d;
   logic [BW-1:0]   saved_bank_q, saved_bank_d;
   logic            trap_err_q, trap_err_d;
   clr_state_e      state_q, state_d;
   logic [BW-1:0]   clr_bank_q, clr_bank_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            clr_we_s, enter_ok_s, ret_ok_s;
   logic            x_bank_ok_s, clr_bank_ok_s;

   assign x_bank_ok_s   = BANK_OK[x_bank_i];
   assign clr_bank_ok_s = BANK_OK[clr_bank_q];

   // Combinational read ports with bypass of the in-flight pipeline write.
   always_comb begin
      rd_data_o = '0;
      for (int i = 0; i < NRP; i++) begin
         if (wr_en_i && (wr_addr_i == rd_addr_i[i*AW +: AW]) && (rd_addr_i[i*AW +: AW] != '0)) begin
            rd_data_o[i*XLEN +: XLEN] = wr_data_i;
         end else begin
            rd_data_o[i*XLEN +: XLEN] = mem_q[cur_bank_q][rd_addr_i[i*AW +: AW]];
         end
      end
   end

   // Cross-bank read and the saved return PC.
   always_comb begin
      if (x_bank_ok_s) begin
         x_rdata_o = mem_q[x_bank_i][x_addr_i];
      end else begin
         x_rdata_o = '0;
      end
      ret_pc_o = mem_q[TRAP_BANK][1];
   end

   // Trap acceptance: a simultaneous return is always dropped in favour of entry.
   always_comb begin
      enter_ok_s   = trap_enter_i && (cur_bank_q != TRAP_B);
      ret_ok_s     = trap_ret_i && !trap_enter_i && (cur_bank_q == TRAP_B);
      trap_err_d   = (trap_enter_i && (cur_bank_q == TRAP_B)) || (trap_ret_i && !ret_ok_s);
      cur_bank_d   = cur_bank_q;
      saved_bank_d = saved_bank_q;
      if (enter_ok_s) begin
         cur_bank_d   = TRAP_B;
         saved_bank_d = cur_bank_q;
      end else if (ret_ok_s) begin
         cur_bank_d   = saved_bank_q;
      end else begin
         cur_bank_d   = cur_bank_q;
      end
   end

   // Per-word next state; the if-chain order is the write priority.
   always_comb begin
      for (int b = 0; b < NBANKS; b++) begin
         for (int r = 0; r < NREGS; r++) begin
            if (r == 0) begin
               mem_d[b][r] = '0;
            end else if (enter_ok_s && (b == TRAP_BANK) && (r == 1)) begin
               mem_d[b][r] = trap_pc_i;
            end else if (enter_ok_s && (b == TRAP_BANK) && (r == 2)) begin
               mem_d[b][r] = trap_cause_i;
            end else if (wr_en_i && (cur_bank_q == BW'(b)) && (wr_addr_i == AW'(r))) begin
               mem_d[b][r] = wr_data_i;
            end else if (x_we_i && x_bank_ok_s && (x_bank_i == BW'(b)) && (x_addr_i == AW'(r))) begin
               mem_d[b][r] = x_wdata_i;
            end else if (clr_we_s && clr_bank_ok_s && (clr_bank_q == BW'(b)) && (cnt_q == AW'(r))) begin
               mem_d[b][r] = '0;
            end else begin
               mem_d[b][r] = mem_q[b][r];
            end
         end
      end
   end

   // Clear FSM next state: walks registers 1..NREGS-1 of the latched bank.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      clr_bank_d = clr_bank_q;
      case (state_q)
         IDLE: begin
            if (clr_req_i) begin
               state_d    = CLEAR;
               cnt_d      = AW'(1);
               clr_bank_d = clr_bank_i;
            end else begin
               state_d    = IDLE;
            end
         end
         CLEAR: begin
            if (cnt_q == LAST_REG) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + AW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == CLEAR);
   end

   // Clear FSM outputs.
   always_comb begin
      clr_we_s = (state_q == CLEAR);
   end

   // Clear FSM and trap control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         clr_bank_q   <= '0;
         busy_q       <= 1'b0;
         cur_bank_q   <= '0;
         saved_bank_q <= '0;
         trap_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clr_bank_q   <= clr_bank_d;
         busy_q       <= busy_d;
         cur_bank_q   <= cur_bank_d;
         saved_bank_q <= saved_bank_d;
         trap_err_q   <= trap_err_d;
      end
   end

   // Register storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NBANKS; b++) begin
            for (int r = 0; r < NREGS; r++) begin
               mem_q[b][r] <= '0;
            end
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign cur_bank_o = cur_bank_q;
   assign trap_err_o = trap_err_q;
   assign busy_o     = busy_q;

endmodule

// File: doc/banked_regfile.md
# banked_regfile

Parametrised multi-bank integer register file for the RISC-V core, replacing the fixed two-bank array and its ad-hoc trap bookkeeping. It provides NRP combinational read ports with same-cycle write bypass, one pipeline write port, and one cross-bank access port for firmware/dual-mode code. It also handles hardware trap entry and return (PC/cause save, bank switch) and a multi-cycle bank clear engine. It sits between ID (reads), WB (writes, trap events) and the MEM-stage dual-mode register window.

## Interface
- XLEN, 32, data width
- NBANKS, 2, number of register banks (≥2)
- NREGS, 32, registers per bank (power of 2, ≥4)
- NRP, 2, number of pipeline read ports
- TRAP_BANK, NBANKS-1, bank entered on trap
- AW / BW, $clog2(NREGS) / $clog2(NBANKS), derived index widths
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NRP*AW  packed read addresses, port i at [i*AW +: AW]
- rd_data  out  NRP*XLEN  read data from current bank, combinational
- wr_en / wr_addr / wr_data  in  1 / AW / XLEN  pipeline write into current bank
- x_bank / x_addr  in  BW / AW  cross-bank access select
- x_we / x_wdata  in  1 / XLEN  cross-bank write
- x_rdata  out  XLEN  cross-bank read data, combinational
- trap_enter  in  1  trap request pulse
- trap_pc / trap_cause  in  XLEN / XLEN  values saved on trap
- trap_ret  in  1  return-from-trap pulse
- ret_pc  out  XLEN  TRAP_BANK register 1, combinational
- cur_bank  out  BW  active bank, registered
- trap_err  out  1  one-cycle pulse on rejected trap event, registered
- clr_req / clr_bank  in  1 / BW  request zeroing of a bank
- busy  out  1  clear engine active, registered

## Operation
- Storage NBANKS×NREGS words. Register 0 of every bank reads 0; writes to it are dropped.
- Reset (async, rst_n=0): all storage 0, cur_bank=0, saved bank=0, trap_err=0, busy=0, FSM IDLE, clear counter 0.
- Read port i returns bank cur_bank[rd_addr_i]. Bypass: if wr_en && wr_addr==rd_addr_i && rd_addr_i!=0, return wr_data.
- x_rdata returns x_bank[x_addr] with no bypass.
- Write priority to the same bank/register in one cycle: trap save > pipeline write > cross-bank write > clear. Lower-priority writes are dropped.
- Pipeline write targets the cur_bank value before the edge. A write in the same cycle as trap_enter lands in the old bank.
- trap_enter accepted when cur_bank!=TRAP_BANK:
  - TRAP_BANK r1 ← trap_pc, r2 ← trap_cause
  - saved bank ← cur_bank, then cur_bank ← TRAP_BANK
- trap_enter while cur_bank==TRAP_BANK: no state change, trap_err=1 next cycle.
- trap_ret accepted when cur_bank==TRAP_BANK: cur_bank ← saved bank. Otherwise ignored and trap_err pulses.
- trap_enter and trap_ret in the same cycle: trap_enter is processed, trap_ret is dropped, trap_err pulses.
- Clear FSM, states IDLE and CLEAR:
  - IDLE & clr_req: latch clr_bank, counter ← 1, go to CLEAR.
  - CLEAR: write 0 to [bank][counter] each cycle, counter+1; after writing NREGS-1, go to IDLE.
  - clr_req while in CLEAR is ignored (no error).
  - Trap and pipeline operations continue normally during CLEAR. Registers already cleared stay writable.

## Timing
- Reads: zero latency, combinational from addresses, storage and bypass.
- Writes: visible to the unbypassed read paths one cycle after the edge.
- cur_bank changes on the edge that samples trap_enter or trap_ret. Reads in the following cycle use the new bank.
- busy=1 from the cycle after clr_req through exactly NREGS-1 cycles, then 0. A new clr_req is accepted on the cycle busy is 0.
- trap_err is high for exactly one cycle, the cycle after the offending edge.
- rst_n low mid-clear: immediate IDLE, busy=0, all storage 0.

## Test plan
- Reset, write r5=0x1234 in bank 0 → port0 reads 0x1234 the next cycle. The same-cycle read of r5 during the write also returns 0x1234 via bypass. A write to r0 followed by a read returns 0.
- cur_bank=0, trap_enter with trap_pc=0x100, trap_cause=0xB → next cycle cur_bank=1, ret_pc=0x100, x_rdata(bank1,r2)=0xB. Then trap_ret → cur_bank=0.
- Second trap_enter while cur_bank=1 → trap_err pulses once, bank1 r1 stays 0x100. trap_ret when cur_bank=0 → trap_err pulses.
- Fill bank 1 with nonzero values, then clr_req(bank 1) → busy high 31 cycles, then all bank 1 registers read 0. Bank 0 is unchanged.
- During CLEAR of bank 0 at counter=10, pipeline writes r10=7 → r10 reads 7 after the clear completes.
- Assert rst_n low mid-clear and mid-trap → outputs return to reset values immediately. Normal operation resumes after release.
